hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It watches register addresses and control bits in the Decode, Execute, Memory and Writeback stages. From them it produces the forwarding selects for both the decode-stage and execute-stage operand muxes, plus the stall and flush controls for Fetch, Decode and Execute (FlushE drives the decode/execute register `flag` input). A small state machine sequences data-memory wait stalls and multi-cycle redirect bubbles after taken branches and jumps.

## Interface
Parameters:
- REDIRECT_BUBBLES, default 1: cycles FlushD is held after a redirect; legal range 1..3.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- RS1_D, RS2_D  in  5  source registers in Decode (InstrD[19:15], [24:20])
- RS1_E, RS2_E, RD_E  in  5  Execute-stage sources and destination
- RegWriteE, LoadE  in  1  Execute writes a register / is a load
- RD_M  in  5  Memory-stage destination
- RegWriteM, LoadM, StoreM  in  1  Memory-stage control
- RD_W  in  5  Writeback destination
- RegWriteW  in  1  Writeback write enable
- RedirectE  in  1  taken branch, JAL or JALR resolved in Execute
- dmem_ack  in  1  data memory completes the access presented this cycle
- ForwardAEDec, ForwardBEDec  out  2  decode mux select: 00 regfile, 01 ResultW
- ForwardAE, ForwardBE  out  2  execute mux select: 00 stage value, 01 ResultW, 10 ALUResultM
- StallF, StallD  out  1  hold PC / fetch-decode register
- FlushD, FlushE  out  1  clear fetch-decode / decode-execute register
- StallM  out  1  hold execute-memory and memory-writeback registers
- stall_cnt, flush_cnt  out  32  performance counters (see Configuration)

## Operation
- Forwarding is combinational. Register x0 never matches.
  - Execute: RS1_E==RD_M and RegWriteM gives 10. Otherwise RS1_E==RD_W and RegWriteW gives 01. Otherwise 00. B side uses RS2_E the same way.
  - Decode: RS1_D==RD_W and RegWriteW gives 01, else 00. Same for RS2_D.
- Load-use hazard (lu) = LoadE and RD_E≠0 and (RD_E==RS1_D or RD_E==RS2_D).
- FSM states: RUN, MEM_WAIT, REDIRECT.
  - RUN:
    - (LoadM or StoreM) and !dmem_ack goes to MEM_WAIT.
    - Else RedirectE goes to REDIRECT, loading bubble counter with REDIRECT_BUBBLES-1.
    - Else stays in RUN.
  - MEM_WAIT:
    - Holds until dmem_ack.
    - On dmem_ack, goes to REDIRECT if a redirect is pending, else to RUN.
  - REDIRECT:
    - Counter decrements each cycle.
    - Returns to RUN when counter==0 and not re-entered.
- Output priority, same cycle: memory wait > redirect > load-use.
  - Memory wait (MEM_WAIT, or RUN with access and !dmem_ack): StallF, StallD and StallM are 1; FlushD and FlushE are 0.
  - Redirect (RedirectE in RUN, or state REDIRECT): FlushD=1. FlushE=1 only in the RedirectE cycle. Stalls are 0.
  - lu with no higher event: StallF=StallD=1, FlushE=1, for exactly one cycle.
- A redirect arriving while a memory wait is active is latched into a one-bit pending register. It is applied on the dmem_ack cycle and the pending bit is cleared.
- A new RedirectE while in REDIRECT reloads the counter.

## Timing
- Forward selects: zero-cycle latency, valid the same cycle as their inputs.
- Stall and flush outputs are combinational from the current state and inputs; the FSM updates on posedge clk.
- A load-use stall lasts exactly 1 cycle. The dependent instruction then receives the load result through ForwardXE=01 from Writeback.
- A redirect holds FlushD for REDIRECT_BUBBLES consecutive cycles, starting with the RedirectE cycle.
- A memory wait lasts from the first !dmem_ack cycle through the dmem_ack cycle, inclusive of the stall.
- Reset, asserted asynchronously at any time including mid-wait or mid-redirect:
  - state goes to RUN;
  - pending bit, bubble counter and perf counters clear to 0;
  - all stall/flush outputs are 0;
  - forward selects follow their inputs;
  - operation resumes on the first clock edge after rst rises.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments each cycle StallD=1;
  - flush_cnt increments each cycle FlushE=1;
  - both saturate at 32'hFFFF_FFFF and clear on reset.
- HAZARD_PERF_EN undefined: counter logic is omitted and both ports are tied to 0.

## Test plan
- Forward priority: RS1_E=5, RD_M=5, RegWriteM=1, RD_W=5, RegWriteW=1 → ForwardAE=10. Then RegWriteM=0 → ForwardAE=01. With RS1_E=0 → 00.
- Load-use: LoadE=1, RD_E=7, RS2_D=7 → StallF=StallD=FlushE=1 for one cycle. Next cycle, with RS2_E=7 and RD_W=7, ForwardBE=01.
- Redirect, REDIRECT_BUBBLES=3: RedirectE pulse → FlushD=1 for 3 cycles, FlushE=1 only in the first.
- Memory wait: LoadM=1 with dmem_ack low for 4 cycles → StallF, StallD and StallM are high for 4 cycles, then for the ack cycle, then all low.
- Redirect during MEM_WAIT, plus an asynchronous reset mid-REDIRECT:
  - RedirectE during MEM_WAIT → FlushD first rises on the dmem_ack cycle.
  - rst low mid-REDIRECT → all outputs 0 immediately; state RUN after release.
- With HAZARD_PERF_EN: 2 load-use stalls plus 5 wait cycles → stall_cnt=7, flush_cnt=2. Preload near max → counters saturate.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage RV32I pipeline: operand forwarding, load-use
// interlock, data-memory wait stalls and redirect bubbles. Define HAZARD_PERF_EN for perf counters.
module hazard_ctrl #(
  parameter int REDIRECT_BUBBLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RS1_E,
  input  logic [4:0]  RS2_E,
  input  logic [4:0]  RD_E,
  input  logic        RegWriteE,
  input  logic        LoadE,
  input  logic [4:0]  RD_M,
  input  logic        RegWriteM,
  input  logic        LoadM,
  input  logic        StoreM,
  input  logic [4:0]  RD_W,
  input  logic        RegWriteW,
  input  logic        RedirectE,
  input  logic        dmem_ack,
  output logic [1:0]  ForwardAEDec,
  output logic [1:0]  ForwardBEDec,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic        StallM,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

  // Counter holds the FlushD cycles still owed after the current one.
  localparam logic [1:0] BUBBLE_LOAD = 2'(REDIRECT_BUBBLES - 1);
  localparam state_t     AFTER_LOAD  = (BUBBLE_LOAD != 2'd0) ? REDIRECT : RUN;

  state_t     state_reg;
  logic       pending_reg;
  logic [1:0] bubble_reg;

  logic access;
  logic mem_wait;
  logic wait_ack;
  logic redirect_apply;
  logic redirect_run;
  logic lu;
  logic lu_stall;

  function automatic logic [1:0] fwd_exec(input logic [4:0] rs, input logic [4:0] rd_m,
                                          input logic rw_m, input logic [4:0] rd_w,
                                          input logic rw_w);
    if (rs != 5'd0 && rw_m && rs == rd_m)
      return 2'b10;
    else if (rs != 5'd0 && rw_w && rs == rd_w)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic [1:0] fwd_dec(input logic [4:0] rs, input logic [4:0] rd_w,
                                         input logic rw_w);
    return (rs != 5'd0 && rw_w && rs == rd_w) ? 2'b01 : 2'b00;
  endfunction

  assign ForwardAE    = fwd_exec(RS1_E, RD_M, RegWriteM, RD_W, RegWriteW);
  assign ForwardBE    = fwd_exec(RS2_E, RD_M, RegWriteM, RD_W, RegWriteW);
  assign ForwardAEDec = fwd_dec(RS1_D, RD_W, RegWriteW);
  assign ForwardBEDec = fwd_dec(RS2_D, RD_W, RegWriteW);

  assign access         = LoadM | StoreM;
  assign mem_wait       = (state_reg == MEM_WAIT) || (state_reg == RUN && access && !dmem_ack);
  assign wait_ack       = (state_reg == MEM_WAIT) && dmem_ack;
  assign redirect_apply = wait_ack && (pending_reg || RedirectE);
  assign redirect_run   = (state_reg == RUN) && !mem_wait && RedirectE;
  assign lu             = LoadE && (RD_E != 5'd0) && (RD_E == RS1_D || RD_E == RS2_D);
  assign lu_stall       = lu && (state_reg == RUN) && !mem_wait && !RedirectE;

  // All controls are forced quiet while reset is held, regardless of inputs.
  assign StallF = rst && (mem_wait || lu_stall);
  assign StallD = rst && (mem_wait || lu_stall);
  assign StallM = rst && mem_wait;
  assign FlushD = rst && (redirect_run || (state_reg == REDIRECT) || redirect_apply);
  assign FlushE = rst && (redirect_run || (state_reg == REDIRECT && RedirectE) || lu_stall);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= RUN;
      pending_reg <= 1'b0;
      bubble_reg  <= 2'd0;
    end else begin
      case (state_reg)
        RUN: begin
          if (access && !dmem_ack) begin
            state_reg   <= MEM_WAIT;
            pending_reg <= RedirectE;
          end else if (RedirectE) begin
            bubble_reg <= BUBBLE_LOAD;
            state_reg  <= AFTER_LOAD;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            pending_reg <= 1'b0;
            if (pending_reg || RedirectE) begin
              bubble_reg <= BUBBLE_LOAD;
              state_reg  <= AFTER_LOAD;
            end else begin
              state_reg <= RUN;
            end
          end else if (RedirectE) begin
            pending_reg <= 1'b1;
          end
        end
        REDIRECT: begin
          if (RedirectE) begin
            bubble_reg <= BUBBLE_LOAD;
            state_reg  <= AFTER_LOAD;
          end else begin
            bubble_reg <= bubble_reg - 2'd1;
            if (bubble_reg == 2'd1)
              state_reg <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Saturating event counters; they stop at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      if (StallD && stall_cnt_reg != 32'hFFFF_FFFF)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (FlushE && flush_cnt_reg != 32'hFFFF_FFFF)
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule
